wb_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the 16-bit three-input select datapath (select codes 00/01/10) among three requesters.
- Generates the 2-bit select, captures the selected operand into a registered output stage, and holds it until the downstream consumer accepts it.
- Returns a one-cycle grant pulse to the winning requester.
- Sits between the execute/memory/immediate sources and the register-file write-back port.

---
 rtl/wb_bus_arbiter_if.sv | 31 +++
 rtl/wb_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/wb_bus_arbiter_if.sv
// wb_bus_arbiter_if
//   Bundles the requester, operand and write-back handshake signals of the
//   three-source round-robin arbiter.
//   master modport : arbiter side (samples req/in1..in3/out_ready, drives
//                    gnt/sel/out_data/out_valid/busy/timeout_err)
//   slave modport  : environment side (requesters, sources and consumer)
interface wb_bus_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [2:0]       req;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic             out_ready;
  logic [2:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic             timeout_err;

  modport master (
    input  req, in1, in2, in3, out_ready,
    output gnt, sel, out_data, out_valid, busy, timeout_err
  );

  modport slave (
    output req, in1, in2, in3, out_ready,
    input  gnt, sel, out_data, out_valid, busy, timeout_err
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter
//   Round-robin arbiter for three write-back sources (execute / memory /
//   immediate). The winner's operand is captured into a registered output
//   stage and held until the consumer accepts it; a one-cycle one-hot grant
//   pulse tells the winner its data was taken. A sticky flag reports a
//   consumer that stalls for TIMEOUT consecutive cycles.
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : wb_bus_arbiter_if.master
//            req[2:0]   request per source (bit i -> in(i+1))
//            in1/2/3    source data, select codes 00/01/10
//            out_ready  consumer accepts out_data this cycle
//            gnt[2:0]   one-hot capture pulse
//            sel[1:0]   select code of current/last grant
//            out_data   registered selected data
//            out_valid  unaccepted transfer held (== busy)
//            busy       high while in XFER
//            timeout_err sticky stall-timeout flag
module wb_bus_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  wb_bus_arbiter_if.master    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       stall_q, stall_d;
  logic             terr_q, terr_d;

  logic [2:0]       eligible;
  logic             arb_en;
  logic             grant;
  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       cand;

  // The source pulsed this cycle is masked so a req still held during its
  // own gnt cycle cannot be granted again on the very next edge.
  assign eligible = bus.req & ~gnt_q;

  // Arbitration happens when the output stage is free or being emptied.
  assign arb_en = (state_q == IDLE) || bus.out_ready;

  // Round-robin search: first eligible index after the last-grant pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int unsigned k = 1; k <= 3; k++) begin
      cand = 2'((32'(ptr_q) + k) % 3);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant = arb_en && win_found;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= 2'd0;
      data_q  <= '0;
      ptr_q   <= 2'd2;
      stall_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (grant) state_d = XFER;
      XFER: if (bus.out_ready && !grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered-output next values
  always_comb begin
    gnt_d   = '0;
    sel_d   = sel_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    stall_d = '0;
    terr_d  = terr_q;

    if (grant) begin
      gnt_d  = 3'b001 << win_idx;
      sel_d  = win_idx;
      ptr_d  = win_idx;
      unique case (win_idx)
        2'd0:    data_d = bus.in1;
        2'd1:    data_d = bus.in2;
        default: data_d = bus.in3;
      endcase
    end

    // Saturating stall count; clears on acceptance and in IDLE.
    if (state_q == XFER && !bus.out_ready) begin
      stall_d = (stall_q >= TIMEOUT_C) ? stall_q : stall_q + 8'd1;
    end

    if (stall_d == TIMEOUT_C) begin
      terr_d = 1'b1;
    end
  end

  // Outputs
  assign bus.gnt         = gnt_q;
  assign bus.sel         = sel_q;
  assign bus.out_data    = data_q;
  assign bus.out_valid   = (state_q == XFER);
  assign bus.busy        = (state_q == XFER);
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter_if #(.WIDTH(16)) bus ();

  wb_bus_arbiter #(
    .WIDTH  (16),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct {
    logic [2:0]  req;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] d3;
    logic        rdy;
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic [15:0] data;
    logic        valid;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] g, input logic [1:0] s,
                         input logic [15:0] d, input logic v, input logic e);
    chk({tag, ".gnt"},         16'(bus.gnt),         16'(g));
    chk({tag, ".sel"},         16'(bus.sel),         16'(s));
    chk({tag, ".out_data"},    bus.out_data,         d);
    chk({tag, ".out_valid"},   16'(bus.out_valid),   16'(v));
    chk({tag, ".busy"},        16'(bus.busy),        16'(v));
    chk({tag, ".timeout_err"}, 16'(bus.timeout_err), 16'(e));
  endtask

  initial begin
    // req, in1, in2, in3, out_ready | gnt, sel, out_data, out_valid
    tbl[0]  = '{3'b111, 16'hA5A5, 16'h1234, 16'hC3C3, 1'b1, 3'b001, 2'd0, 16'hA5A5, 1'b1};
    tbl[1]  = '{3'b111, 16'hA5A5, 16'h1234, 16'hC3C3, 1'b1, 3'b010, 2'd1, 16'h1234, 1'b1};
    tbl[2]  = '{3'b110, 16'hA5A5, 16'h1234, 16'hC3C3, 1'b1, 3'b100, 2'd2, 16'hC3C3, 1'b1};
    tbl[3]  = '{3'b100, 16'hA5A5, 16'h1234, 16'hC3C3, 1'b1, 3'b000, 2'd2, 16'hC3C3, 1'b0};
    tbl[4]  = '{3'b000, 16'hA5A5, 16'h1234, 16'hC3C3, 1'b1, 3'b000, 2'd2, 16'hC3C3, 1'b0};
    tbl[5]  = '{3'b001, 16'hA5A5, 16'h1234, 16'hC3C3, 1'b1, 3'b001, 2'd0, 16'hA5A5, 1'b1};
    tbl[6]  = '{3'b000, 16'hA5A5, 16'h1234, 16'hC3C3, 1'b1, 3'b000, 2'd0, 16'hA5A5, 1'b0};
    tbl[7]  = '{3'b101, 16'hA5A5, 16'h1234, 16'hC3C3, 1'b1, 3'b100, 2'd2, 16'hC3C3, 1'b1};
    tbl[8]  = '{3'b101, 16'h5A5A, 16'h1234, 16'hC3C3, 1'b1, 3'b001, 2'd0, 16'h5A5A, 1'b1};
    tbl[9]  = '{3'b101, 16'h5A5A, 16'h1234, 16'hC3C3, 1'b1, 3'b100, 2'd2, 16'hC3C3, 1'b1};
    tbl[10] = '{3'b101, 16'h5A5A, 16'h1234, 16'hC3C3, 1'b1, 3'b001, 2'd0, 16'h5A5A, 1'b1};
    tbl[11] = '{3'b000, 16'h5A5A, 16'h1234, 16'hC3C3, 1'b1, 3'b000, 2'd0, 16'h5A5A, 1'b0};

    bus.req       = '0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.in3       = '0;
    bus.out_ready = 1'b0;

    // Reset state
    step();
    step();
    chk_all("reset", 3'b000, 2'd0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    // Round-robin sequences from a fresh reset (pointer = 2)
    for (int i = 0; i < 12; i++) begin
      bus.req       = tbl[i].req;
      bus.in1       = tbl[i].d1;
      bus.in2       = tbl[i].d2;
      bus.in3       = tbl[i].d3;
      bus.out_ready = tbl[i].rdy;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].data, tbl[i].valid, 1'b0);
    end

    // Hold under backpressure; timeout flag after 4 stalled cycles
    bus.req       = 3'b010;
    bus.in2       = 16'h1234;
    bus.out_ready = 1'b0;
    step();
    chk_all("hold_grant", 3'b010, 2'd1, 16'h1234, 1'b1, 1'b0);
    bus.req = 3'b000;
    bus.in2 = 16'hFFFF;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk_all($sformatf("stall%0d", k), 3'b000, 2'd1, 16'h1234, 1'b1, (k >= 4));
    end
    bus.out_ready = 1'b1;
    step();
    chk_all("stall_accept", 3'b000, 2'd1, 16'h1234, 1'b0, 1'b1);

    // Flag stays sticky across further transfers
    bus.req = 3'b100;
    bus.in3 = 16'hBEEF;
    step();
    chk_all("sticky_grant", 3'b100, 2'd2, 16'hBEEF, 1'b1, 1'b1);
    bus.req = 3'b000;
    step();
    chk_all("sticky_idle", 3'b000, 2'd2, 16'hBEEF, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a transfer
    bus.req       = 3'b010;
    bus.in2       = 16'h0777;
    bus.out_ready = 1'b0;
    step();
    chk_all("pre_rst", 3'b010, 2'd1, 16'h0777, 1'b1, 1'b1);
    bus.req = 3'b000;
    rst     = 1'b1;
    #1;
    chk_all("async_rst", 3'b000, 2'd0, 16'h0000, 1'b0, 1'b0);
    step();
    rst           = 1'b0;
    bus.req       = 3'b111;
    bus.in1       = 16'h0101;
    bus.out_ready = 1'b1;
    step();
    chk_all("post_rst", 3'b001, 2'd0, 16'h0101, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
